// File: rtl/keypad_scan_ctrl.sv
`timescale 1ns/1ps
// keypad_scan_ctrl: scans a 4x4 active-low matrix keypad one column at a time,
// debounces over whole scans and hands one key code per keystroke downstream
// through a valid/ack handshake, plus a held flag and a sticky overrun flag.
module keypad_scan_ctrl #(
  parameter int SCAN_TICKS     = 100000,
  parameter int SETTLE_TICKS   = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_LAST   = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] TICK_SAMPLE = TW'(SETTLE_TICKS - 1);
  localparam logic [3:0]    DEB_TARGET  = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_t;

  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic [3:0]    row_meta;
  logic [3:0]    row_s;
  logic [TW-1:0] tick;
  logic [1:0]    col;
  logic [15:0]   scan_vec;
  logic          scan_done;
  logic [4:0]    low_cnt;
  logic [3:0]    cand_code;
  logic          cand_key;
  logic          match;
  state_t        state, state_nx;
  logic [3:0]    deb_cnt, cnt_nx, cnt_inc;
  logic [3:0]    deb_key, key_nx;
  logic          accept;

  // Key code for scan_vec bit index {col, row}
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd0:  code_of = 4'h1;  4'd1:  code_of = 4'h4;
      4'd2:  code_of = 4'h7;  4'd3:  code_of = 4'h0;
      4'd4:  code_of = 4'h2;  4'd5:  code_of = 4'h5;
      4'd6:  code_of = 4'h8;  4'd7:  code_of = 4'hF;
      4'd8:  code_of = 4'h3;  4'd9:  code_of = 4'h6;
      4'd10: code_of = 4'h9;  4'd11: code_of = 4'hE;
      4'd12: code_of = 4'hA;  4'd13: code_of = 4'hB;
      4'd14: code_of = 4'hC;  default: code_of = 4'hD;
    endcase
  endfunction

  // Reset asserts immediately but is released in step with the clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_s    <= row_meta;
    end
  end

  // Slot timer and column pointer; a pulse marks the end of the column-3 slot
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tick      <= '0;
      col       <= 2'd0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= (tick == TICK_LAST) && (col == 2'd3);
      if (tick == TICK_LAST) begin
        tick <= '0;
        col  <= col + 2'd1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // Capture the settled rows of the active column into the scan image
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) scan_vec <= 16'hFFFF;
    else if (tick == TICK_SAMPLE) scan_vec[{col, 2'b00} +: 4] <= row_s;
  end

  // Active-low one-hot column drive follows the column pointer directly
  always_comb begin
    col_n = ~(4'b0001 << col);
  end

  // Reduce the scan image to a single key, no key, or ghosting (several keys)
  always_comb begin
    low_cnt   = 5'd0;
    cand_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (!scan_vec[i]) begin
        low_cnt   = low_cnt + 5'd1;
        cand_code = code_of(4'(i));
      end
    end
    cand_key = (low_cnt == 5'd1);
    match    = cand_key && (cand_code == deb_key);
    cnt_inc  = (deb_cnt == 4'hF) ? 4'hF : deb_cnt + 4'd1;
  end

  // Debounce state register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state   <= IDLE;
      deb_cnt <= 4'd0;
      deb_key <= 4'd0;
    end else begin
      state   <= state_nx;
      deb_cnt <= cnt_nx;
      deb_key <= key_nx;
    end
  end

  // Debounce next-state logic, advancing once per completed scan
  always_comb begin
    state_nx = state;
    cnt_nx   = deb_cnt;
    key_nx   = deb_key;
    if (scan_done) begin
      case (state)
        IDLE: if (cand_key) begin
          state_nx = PRESS_DEB;
          key_nx   = cand_code;
          cnt_nx   = 4'd1;
        end
        PRESS_DEB: if (match) begin
          if (cnt_inc >= DEB_TARGET) begin
            state_nx = HELD;
            cnt_nx   = 4'd0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
        HELD: if (!match) begin
          state_nx = REL_DEB;
          cnt_nx   = 4'd1;
        end
        default: if (match) begin
          state_nx = HELD;
          cnt_nx   = 4'd0;
        end else if (cnt_inc >= DEB_TARGET) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt_inc;
        end
      endcase
    end
  end

  // Debounce outputs: held flag and the one-cycle accept strobe
  always_comb begin
    key_held = (state == HELD) || (state == REL_DEB);
    accept   = (state == PRESS_DEB) && (state_nx == HELD);
  end

  // Event register: oldest unacknowledged event wins, a lost press sets overrun
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (accept) begin
      if (key_valid && !key_ack) begin
        overrun <= 1'b1;
      end else begin
        key_code  <= deb_key;
        key_valid <= 1'b1;
        overrun   <= 1'b0;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
// tb_keypad_scan_ctrl: drives a modelled keypad matrix against the scanner and
// checks key events against a queue of expected events.
module tb_keypad_scan_ctrl;

  localparam int SCAN = 64;

  typedef struct {
    logic [3:0] code;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       overrun;
  logic [15:0] keys = 16'h0;
  exp_t       sbq[$];
  int         compared = 0;
  int         mismatched = 0;

  keypad_scan_ctrl #(.SCAN_TICKS(16), .SETTLE_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_held(key_held), .overrun(overrun)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when that column is driven low
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[4*c+r] && !col_n[c]) row_n[r] = 1'b0;
  end

  function automatic logic [15:0] keyAt(input int r, input int c);
    logic [15:0] one;
    one = 16'h1;
    return one << (4*c + r);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] k);
    keys = k;
  endtask

  task automatic expectEvent(input logic [3:0] code, input logic ovr);
    exp_t e;
    e.code = code;
    e.ovr  = ovr;
    sbq.push_back(e);
  endtask

  // Park on the first negedge of a new scan (column 0 just selected)
  task automatic alignScan();
    bit seen3 = 0;
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (col_n == 4'b0111) seen3 = 1;
      else if (seen3 && col_n == 4'b1110) found = 1;
    end
    if (!found) checkOutput("align_timeout", 16'd0, 16'd1);
  endtask

  // Wait (bounded) for a pending event and compare it with the queue head
  task automatic waitEvent(input string tag, input int budget);
    exp_t e;
    int n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!key_valid) begin
      checkOutput({tag, "_timeout"}, 16'd0, 16'd1);
    end else if (sbq.size() == 0) begin
      checkOutput({tag, "_unexpected"}, 16'd1, 16'd0);
    end else begin
      e = sbq.pop_front();
      checkOutput({tag, "_code"}, 16'(key_code), 16'(e.code));
      checkOutput({tag, "_ovr"}, 16'(overrun), 16'(e.ovr));
    end
  endtask

  task automatic ackEvent(input string tag);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    checkOutput({tag, "_ack_valid"}, 16'(key_valid), 16'd0);
    checkOutput({tag, "_ack_ovr"}, 16'(overrun), 16'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_col"}, 16'(col_n), 16'hE);
    checkOutput({tag, "_code"}, 16'(key_code), 16'd0);
    checkOutput({tag, "_valid"}, 16'(key_valid), 16'd0);
    checkOutput({tag, "_held"}, 16'(key_held), 16'd0);
    checkOutput({tag, "_ovr"}, 16'(overrun), 16'd0);
  endtask

  // Watchdog so a stuck run still ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] colSeq[4];
    bit sawValid;
    colSeq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // 1: reset values, column rotation, no spurious events
    waitCycles(3);
    checkResetValues("rst");
    rst_n = 1'b1;
    alignScan();
    for (int k = 0; k < 8; k++) begin
      waitCycles(8);
      checkOutput($sformatf("col_seq%0d", k), 16'(col_n), 16'(colSeq[k % 4]));
      waitCycles(8);
    end
    sawValid = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (key_valid) sawValid = 1;
    end
    checkOutput("idle_no_event", 16'(sawValid), 16'd0);

    // 2: key 6 (r1/c2) held for 5 scans
    alignScan();
    applyStimulus(keyAt(1, 2));
    expectEvent(4'h6, 1'b0);
    waitCycles(3*SCAN - 8);
    checkOutput("t2_early", 16'(key_valid), 16'd0);
    waitEvent("t2", 24);
    checkOutput("t2_held", 16'(key_held), 16'd1);
    ackEvent("t2");
    waitCycles(2*SCAN - 20);
    checkOutput("t2_no_repeat", 16'(key_valid), 16'd0);
    applyStimulus(16'h0);
    waitCycles(4*SCAN);
    checkOutput("t2_released", 16'(key_held), 16'd0);

    // 3: key 5 bounces every 40 clk, then settles pressed
    alignScan();
    for (int i = 0; i < 7; i++) begin
      applyStimulus((i % 2 == 0) ? keyAt(1, 1) : 16'h0);
      waitCycles(40);
    end
    expectEvent(4'h5, 1'b0);
    waitCycles(160);
    checkOutput("t3_early", 16'(key_valid), 16'd0);
    waitEvent("t3", 30);
    ackEvent("t3");
    waitCycles(2*SCAN);
    applyStimulus(16'h0);
    waitCycles(4*SCAN);
    checkOutput("t3_single", 16'(key_valid), 16'd0);

    // 4: press/release 9, then press D without ack -> overrun, code stays 9
    alignScan();
    applyStimulus(keyAt(2, 2));
    expectEvent(4'h9, 1'b1);
    waitCycles(4*SCAN);
    checkOutput("t4_first_valid", 16'(key_valid), 16'd1);
    applyStimulus(16'h0);
    waitCycles(4*SCAN);
    applyStimulus(keyAt(3, 3));
    waitCycles(4*SCAN);
    checkOutput("t4_held_d", 16'(key_held), 16'd1);
    waitEvent("t4", 1);
    ackEvent("t4");
    applyStimulus(16'h0);
    waitCycles(4*SCAN);

    // 5: keys 1 and 2 together (ghost), then release 2
    alignScan();
    applyStimulus(keyAt(0, 0) | keyAt(0, 1));
    waitCycles(4*SCAN);
    checkOutput("t5_multi_valid", 16'(key_valid), 16'd0);
    checkOutput("t5_multi_held", 16'(key_held), 16'd0);
    applyStimulus(keyAt(0, 0));
    expectEvent(4'h1, 1'b0);
    waitCycles(3*SCAN - 8);
    checkOutput("t5_early", 16'(key_valid), 16'd0);
    waitEvent("t5", 24);
    ackEvent("t5");
    applyStimulus(16'h0);
    waitCycles(4*SCAN);

    // 6: reset while an event is pending and a new press is debouncing
    alignScan();
    applyStimulus(keyAt(0, 2));
    waitCycles(4*SCAN);
    checkOutput("t6_pending", 16'(key_valid), 16'd1);
    applyStimulus(16'h0);
    waitCycles(4*SCAN);
    applyStimulus(keyAt(1, 2));
    waitCycles(2*SCAN);
    #3 rst_n = 1'b0;
    #1 checkResetValues("t6_async");
    waitCycles(3);
    rst_n = 1'b1;
    expectEvent(4'h6, 1'b0);
    waitCycles(150);
    checkOutput("t6_relearn_early", 16'(key_valid), 16'd0);
    waitEvent("t6", 60);
    ackEvent("t6");
    applyStimulus(16'h0);
    waitCycles(4*SCAN);

    checkOutput("sb_empty", 16'(sbq.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
